// File: rtl/reg_wb_arbiter.sv
// Register-file write-port controller: arbitrates writeback vs long-latency
// unit, tracks pending long-latency destinations, flags decode read hazards.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   wb_valid/wb_reg/wb_data     pipeline writeback request
//   wb_stall                    pipeline request not taken this cycle
//   lu_valid/lu_reg/lu_data     long-latency unit write request
//   lu_ready                    long-latency request granted this cycle
//   iss_valid/iss_reg           long-latency op issued (mark destination busy)
//   rd_reg1/rd_reg2, hazard     decode read registers and hazard flag
//   RegWrite/w_reg/w_data       registered register-file write port
module reg_wb_arbiter #(
    parameter int DW       = 64,
    parameter int MAX_WAIT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_valid,
    input  logic [4:0]    wb_reg,
    input  logic [DW-1:0] wb_data,
    output logic          wb_stall,
    input  logic          lu_valid,
    input  logic [4:0]    lu_reg,
    input  logic [DW-1:0] lu_data,
    output logic          lu_ready,
    input  logic          iss_valid,
    input  logic [4:0]    iss_reg,
    input  logic [4:0]    rd_reg1,
    input  logic [4:0]    rd_reg2,
    output logic          hazard,
    output logic          RegWrite,
    output logic [4:0]    w_reg,
    output logic [DW-1:0] w_data
);

    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);
    localparam logic [4:0] X31 = 5'd31;

    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_nxt;
    logic          lu_gnt;
    logic          wb_gnt;
    logic          any_gnt;
    logic [4:0]    sel_reg;
    logic [DW-1:0] sel_data;
    logic          out_src_lu;
    logic [30:0]   busy;
    logic [30:0]   busy_set;
    logic [30:0]   busy_clr;
    logic [30:0]   busy_nxt;
    logic [31:0]   busy_ext;

    // The pipeline wins ties until the long-latency unit has lost
    // MAX_WAIT consecutive cycles; then it is forced through.
    always_comb begin
        lu_gnt  = lu_valid && (!wb_valid || (wait_cnt == WAIT_MAX));
        wb_gnt  = wb_valid && !lu_gnt;
        any_gnt = lu_gnt || wb_gnt;
    end

    assign lu_ready = lu_gnt;
    assign wb_stall = wb_valid && !wb_gnt;

    always_comb begin
        wait_nxt = wait_cnt;
        if (!lu_valid || lu_gnt) begin
            wait_nxt = '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_nxt = wait_cnt + 1'b1;
        end
    end

    always_comb begin
        sel_reg  = wb_reg;
        sel_data = wb_data;
        unique case (1'b1)
            lu_gnt: begin
                sel_reg  = lu_reg;
                sel_data = lu_data;
            end
            default: begin
                sel_reg  = wb_reg;
                sel_data = wb_data;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_nxt;
        end
    end

    // X31 writes are granted but never reach the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite   <= 1'b0;
            w_reg      <= '0;
            w_data     <= '0;
            out_src_lu <= 1'b0;
        end else if (any_gnt) begin
            RegWrite   <= (sel_reg != X31);
            w_reg      <= sel_reg;
            w_data     <= sel_data;
            out_src_lu <= lu_gnt;
        end else begin
            RegWrite   <= 1'b0;
        end
    end

    // Clear lands on the same edge as the register-file write;
    // a same-edge issue to that register keeps it busy.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        for (int i = 0; i < 31; i++) begin
            busy_set[i] = iss_valid && (iss_reg == 5'(i));
            busy_clr[i] = RegWrite && out_src_lu && (w_reg == 5'(i));
        end
        busy_nxt = (busy & ~busy_clr) | busy_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // X31 maps onto a constant-zero bit, so it never raises a hazard.
    assign busy_ext = {1'b0, busy};
    assign hazard   = busy_ext[rd_reg1] || busy_ext[rd_reg2];

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Controller for the register-file write port.
- Arbitrates the single write port between the pipeline writeback stage and the long-latency unit (loads / multi-cycle ALU ops) over valid/ready.
- Keeps a scoreboard of registers with pending long-latency writes and flags read hazards to the decode stage.
- Drives RegWrite / w_reg / w_data of the register file from registered outputs.

Parameters:
DW, 64, data width (equals `WORD)
MAX_WAIT, 3, consecutive lost cycles after which the long-latency unit overrides the pipeline (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wb_valid  in  1  pipeline writeback request
wb_reg  in  5  pipeline destination register
wb_data  in  DW  pipeline write data
wb_stall  out  1  pipeline request not taken this cycle; hold wb_* stable
lu_valid  in  1  long-latency unit write request
lu_reg  in  5  long-latency destination register
lu_data  in  DW  long-latency write data
lu_ready  out  1  long-latency request granted this cycle
iss_valid  in  1  long-latency op issued; mark iss_reg busy
iss_reg  in  5  destination of issued op
rd_reg1  in  5  decode read register 1
rd_reg2  in  5  decode read register 2
hazard  out  1  rd_reg1 or rd_reg2 has a pending long-latency write
RegWrite  out  1  register-file write enable
w_reg  out  5  register-file write address
w_data  out  DW  register-file write data

Behaviour:
- Reset (async, active-low): RegWrite=0, w_reg=0, w_data=0, busy[30:0]=0, wait_cnt=0, out_src_lu=0. Reset mid-operation discards all pending scoreboard state and any in-flight output write.
- Grant (combinational):
  - only wb_valid -> pipeline
  - only lu_valid -> lu
  - both valid -> lu if wait_cnt==MAX_WAIT, else pipeline
- lu_ready = lu granted. wb_stall = wb_valid && !pipeline granted.
- wait_cnt increments when lu_valid && !lu_ready, saturating at MAX_WAIT. It clears to 0 when lu is granted or lu_valid=0.
- Output register, updated on each rising edge:
  - any grant: w_reg/w_data <= granted reg/data; RegWrite <= (granted reg != 31); out_src_lu <= lu granted.
  - no grant: RegWrite <= 0; w_reg/w_data hold.
- Latency: request accepted at edge N; RegWrite high in cycle N..N+1; register file written at edge N+1.
- Writes to X31 are accepted (ready/no stall) and dropped (RegWrite=0).
- Scoreboard:
  - Set: on an edge with iss_valid && iss_reg!=31, busy[iss_reg] <= 1.
  - Clear: on an edge with RegWrite && out_src_lu, busy[w_reg] <= 0, so the clear coincides with the register-file write.
  - Set and clear of the same register on the same edge: set wins.
  - Issue to an already-busy register: stays busy; no error.
- hazard = (rd_reg1!=31 && busy[rd_reg1]) || (rd_reg2!=31 && busy[rd_reg2]). It is combinational from the registered busy bits; a same-cycle issue is not visible until the next cycle.
- A pipeline write to a busy register is not blocked. Preventing it is decode's responsibility via hazard.
- Requesters hold valid/reg/data stable until granted. The arbiter does not buffer.

Test Plan:
- Reset then idle -> RegWrite=0, w_reg=0, w_data=0, hazard=0, lu_ready=0, wb_stall=0.
- wb_valid=1, wb_reg=5, wb_data=0x1234, one cycle -> next cycle RegWrite=1, w_reg=5, w_data=0x1234, wb_stall=0; following cycle RegWrite=0.
- wb_valid and lu_valid both held high continuously (lu_reg=7), MAX_WAIT=3 -> pipeline granted 3 cycles; lu_ready=1 and wb_stall=1 in the 4th cycle; w_reg=7 the cycle after; wait_cnt back to 0.
- iss_valid, iss_reg=9; then rd_reg1=9 -> hazard=1 from the next cycle. lu write to 9 granted at edge N -> hazard stays 1 through cycle N..N+1 and drops after edge N+1.
- iss_reg=31 and wb_reg=31 with valid -> busy unchanged, hazard=0, wb_stall=0, RegWrite stays 0.
- busy[9] set, lu write to 9 in flight (RegWrite=1, out_src_lu=1) with iss_valid for reg 9 on the same edge -> busy[9] remains 1; assert rst_n=0 mid-sequence -> all busy cleared and RegWrite=0 immediately.
